// File: rtl/sump_cmd_parser.sv
// rtl/sump_cmd_parser.sv - SUMP/OLS command parser, capture config registers and ID/metadata replies
module sump_cmd_parser #(
  parameter int DIV_W       = 24,
  parameter int TIMEOUT_CYC = 480000,
  parameter int META_LEN    = 32
) (
  input  logic             CAP_CLK,
  input  logic             RST,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             arm,
  output logic             soft_reset,
  output logic [7:0]       trig_mask,
  output logic [7:0]       trig_value,
  output logic [DIV_W-1:0] cap_div,
  output logic [15:0]      read_count,
  output logic [15:0]      delay_count,
  output logic [7:0]       cap_flags,
  output logic             reply_busy
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]      ID_LAST   = 5'd3;
  localparam logic [4:0]      META_LAST = 5'(META_LEN - 1);

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_ID    = 8'h02;
  localparam logic [7:0] OP_META  = 8'h04;
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_COUNT = 8'h81;
  localparam logic [7:0] OP_FLAGS = 8'h82;
  localparam logic [7:0] OP_MASK  = 8'hC0;
  localparam logic [7:0] OP_VALUE = 8'hC1;

  typedef enum logic [0:0] {P_IDLE, P_COLLECT} p_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT_HI, R_WAIT_LO} r_state_t;

  p_state_t        p_state;
  logic [7:0]      opcode;
  logic [2:0]      idx;
  logic [7:0]      pay_b1;
  logic [7:0]      pay_b2;
  logic [7:0]      pay_b3;
  logic [TO_W-1:0] idle_cnt;

  r_state_t        r_state;
  logic            rom_sel;
  logic [4:0]      ptr;
  logic [7:0]      rom_byte;
  logic [4:0]      last_ptr;

  logic            short_hit;
  logic            do_abort;
  logic            do_id;
  logic            do_meta;

  // Short-command decode seen by the reply engine in the same edge the parser consumes the byte
  always_comb begin
    short_hit = rx_ready && (p_state == P_IDLE) && !rx_data[7];
    do_abort  = short_hit && (rx_data == OP_RESET);
    do_id     = short_hit && (rx_data == OP_ID);
    do_meta   = short_hit && (rx_data == OP_META);
  end

  // Parser: opcode/payload assembly, partial-command timeout, strobes and config registers
  always_ff @(posedge CAP_CLK or posedge RST) begin
    if (RST) begin
      p_state     <= P_IDLE;
      opcode      <= 8'h00;
      idx         <= 3'd0;
      pay_b1      <= 8'h00;
      pay_b2      <= 8'h00;
      pay_b3      <= 8'h00;
      idle_cnt    <= '0;
      arm         <= 1'b0;
      soft_reset  <= 1'b0;
      trig_mask   <= 8'h00;
      trig_value  <= 8'h00;
      cap_div     <= DIV_W'(3);
      read_count  <= 16'h0000;
      delay_count <= 16'h0000;
      cap_flags   <= 8'h00;
    end else begin
      arm        <= 1'b0;
      soft_reset <= 1'b0;
      case (p_state)
        P_IDLE: begin
          idle_cnt <= '0;
          if (rx_ready) begin
            if (rx_data[7]) begin
              opcode  <= rx_data;
              idx     <= 3'd1;
              p_state <= P_COLLECT;
            end else begin
              arm        <= (rx_data == OP_ARM);
              soft_reset <= (rx_data == OP_RESET);
            end
          end
        end
        P_COLLECT: begin
          if (rx_ready) begin
            idle_cnt <= '0;
            case (idx)
              3'd1:    pay_b1 <= rx_data;
              3'd2:    pay_b2 <= rx_data;
              3'd3:    pay_b3 <= rx_data;
              default: ;
            endcase
            if (idx == 3'd4) begin
              // Final payload byte: every field of the command lands in this one edge
              p_state <= P_IDLE;
              case (opcode)
                OP_DIV:   cap_div <= DIV_W'({pay_b3, pay_b2, pay_b1});
                OP_COUNT: begin
                  read_count  <= {pay_b2, pay_b1};
                  delay_count <= {rx_data, pay_b3};
                end
                OP_FLAGS: cap_flags  <= pay_b1;
                OP_MASK:  trig_mask  <= pay_b1;
                OP_VALUE: trig_value <= pay_b1;
                default:  ;
              endcase
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (idle_cnt == TO_LAST) begin
            // Host went quiet mid-command; drop the partial command untouched
            p_state  <= P_IDLE;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  // Reply length depends on which ROM is being streamed
  always_comb begin
    last_ptr = rom_sel ? META_LAST : ID_LAST;
  end

  // Reply ROMs: "1ALS" identity and the OLS metadata block, indexed by ptr
  always_comb begin
    rom_byte = 8'h00;
    if (!rom_sel) begin
      case (ptr[1:0])
        2'd0:    rom_byte = 8'h31;
        2'd1:    rom_byte = 8'h41;
        2'd2:    rom_byte = 8'h4C;
        default: rom_byte = 8'h53;
      endcase
    end else begin
      case (ptr)
        5'd0:    rom_byte = 8'h01;  // device name key
        5'd1:    rom_byte = 8'h69;  // i
        5'd2:    rom_byte = 8'h43;  // C
        5'd3:    rom_byte = 8'h45;  // E
        5'd4:    rom_byte = 8'h43;  // C
        5'd5:    rom_byte = 8'h61;  // a
        5'd6:    rom_byte = 8'h70;  // p
        5'd7:    rom_byte = 8'h74;  // t
        5'd8:    rom_byte = 8'h75;  // u
        5'd9:    rom_byte = 8'h72;  // r
        5'd10:   rom_byte = 8'h65;  // e
        5'd11:   rom_byte = 8'h00;
        5'd12:   rom_byte = 8'h02;  // firmware version key
        5'd13:   rom_byte = 8'h30;  // 0
        5'd14:   rom_byte = 8'h2E;  // .
        5'd15:   rom_byte = 8'h31;  // 1
        5'd16:   rom_byte = 8'h00;
        5'd17:   rom_byte = 8'h21;  // sample memory: 8192
        5'd18:   rom_byte = 8'h00;
        5'd19:   rom_byte = 8'h00;
        5'd20:   rom_byte = 8'h20;
        5'd21:   rom_byte = 8'h00;
        5'd22:   rom_byte = 8'h23;  // max sample rate: 48 MHz
        5'd23:   rom_byte = 8'h02;
        5'd24:   rom_byte = 8'hDC;
        5'd25:   rom_byte = 8'h6C;
        5'd26:   rom_byte = 8'h00;
        5'd27:   rom_byte = 8'h40;  // probe count: 8
        5'd28:   rom_byte = 8'h08;
        5'd29:   rom_byte = 8'h41;  // protocol version: 2
        5'd30:   rom_byte = 8'h02;
        default: rom_byte = 8'h00;  // end of metadata
      endcase
    end
  end

  // Reply engine: one byte per uart_tx busy cycle; a SUMP reset cancels it between bytes
  always_ff @(posedge CAP_CLK or posedge RST) begin
    if (RST) begin
      r_state    <= R_IDLE;
      rom_sel    <= 1'b0;
      ptr        <= 5'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      reply_busy <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (do_abort) begin
        r_state    <= R_IDLE;
        reply_busy <= 1'b0;
      end else begin
        case (r_state)
          R_IDLE: begin
            if (do_id || do_meta) begin
              rom_sel    <= do_meta;
              ptr        <= 5'd0;
              r_state    <= R_SEND;
              reply_busy <= 1'b1;
            end
          end
          R_SEND: begin
            if (!tx_busy) begin
              tx_data  <= rom_byte;
              tx_start <= 1'b1;
              r_state  <= R_WAIT_HI;
            end
          end
          R_WAIT_HI: begin
            if (tx_busy) begin
              r_state <= R_WAIT_LO;
            end
          end
          R_WAIT_LO: begin
            if (!tx_busy) begin
              if (ptr == last_ptr) begin
                r_state    <= R_IDLE;
                reply_busy <= 1'b0;
              end else begin
                ptr     <= ptr + 5'd1;
                r_state <= R_SEND;
              end
            end
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

endmodule
